// File: rtl/stack_queue_buffer.sv
// Operand register file for the stack/queue calculator: LIFO or FIFO reads chosen by the mode switch,
// with the first two operands always presented to the ALU and illegal strobes flagged on err.
module stack_queue_buffer #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 8,
    parameter int ADDR_W = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mode,
    input  logic              push,
    input  logic              pop,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] dout0,
    output logic [DATA_W-1:0] dout1,
    output logic [ADDR_W:0]   count,
    output logic              empty,
    output logic              full,
    output logic              err
);

    localparam logic [ADDR_W-1:0] PTR_ONE    = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] PTR_TWO    = ADDR_W'(2);
    localparam logic [ADDR_W:0]   CNT_ONE    = (ADDR_W + 1)'(1);
    localparam logic [ADDR_W:0]   CNT_TWO    = (ADDR_W + 1)'(2);
    localparam logic [ADDR_W:0]   FULL_COUNT = (ADDR_W + 1)'(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [ADDR_W-1:0] head;
    logic [ADDR_W-1:0] tail;
    logic [ADDR_W:0]   count_q;
    logic              mode_q;
    logic              err_q;

    logic              flip;
    logic              is_empty;
    logic              is_full;
    logic              do_write;
    logic              do_err;
    logic [ADDR_W-1:0] wr_addr;
    logic [ADDR_W-1:0] head_nxt;
    logic [ADDR_W-1:0] tail_nxt;
    logic [ADDR_W:0]   count_nxt;
    logic [ADDR_W-1:0] rd0_addr;
    logic [ADDR_W-1:0] rd1_addr;

    assign flip     = (mode != mode_q);
    assign is_empty = (count_q == '0);
    assign is_full  = (count_q == FULL_COUNT);

    // Next-state decode; a mode flip takes priority and silently discards any strobe.
    always_comb begin
        head_nxt  = head;
        tail_nxt  = tail;
        count_nxt = count_q;
        do_write  = 1'b0;
        wr_addr   = tail;
        do_err    = 1'b0;
        if (flip) begin
            head_nxt  = '0;
            tail_nxt  = '0;
            count_nxt = '0;
        end else if (push && pop) begin
            do_write = 1'b1;
            if (is_empty) begin
                tail_nxt  = tail + PTR_ONE;
                count_nxt = CNT_ONE;
                do_err    = 1'b1;
            end else if (mode_q) begin
                wr_addr = tail - PTR_ONE;
            end else begin
                head_nxt = head + PTR_ONE;
                tail_nxt = tail + PTR_ONE;
            end
        end else if (push) begin
            if (is_full) begin
                do_err = 1'b1;
            end else begin
                do_write  = 1'b1;
                tail_nxt  = tail + PTR_ONE;
                count_nxt = count_q + CNT_ONE;
            end
        end else if (pop) begin
            if (is_empty) begin
                do_err = 1'b1;
            end else begin
                count_nxt = count_q - CNT_ONE;
                if (mode_q) begin
                    tail_nxt = tail - PTR_ONE;
                end else begin
                    head_nxt = head + PTR_ONE;
                end
            end
        end
    end

    // mode_q resets to stack so a queue-mode switch at release flushes on the first edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            head    <= '0;
            tail    <= '0;
            count_q <= '0;
            mode_q  <= 1'b1;
            err_q   <= 1'b0;
        end else begin
            if (do_write) begin
                mem[wr_addr] <= din;
            end
            head    <= head_nxt;
            tail    <= tail_nxt;
            count_q <= count_nxt;
            mode_q  <= mode;
            err_q   <= do_err;
        end
    end

    always_comb begin
        rd0_addr = head;
        rd1_addr = head + PTR_ONE;
        if (mode_q) begin
            rd0_addr = tail - PTR_ONE;
            rd1_addr = tail - PTR_TWO;
        end
    end

    // Gating by occupancy keeps stale register-file contents off the operand path.
    assign dout0 = (count_q >= CNT_ONE) ? mem[rd0_addr] : '0;
    assign dout1 = (count_q >= CNT_TWO) ? mem[rd1_addr] : '0;
    assign count = count_q;
    assign empty = is_empty;
    assign full  = is_full;
    assign err   = err_q;

endmodule

// File: tb/tb_stack_queue_buffer.sv
// Self-checking bench for stack_queue_buffer: directed scenarios plus randomized traffic
// compared against a list-based model of stack/queue behaviour.
module tb_stack_queue_buffer;

    localparam int DATA_W = 32;
    localparam int DEPTH  = 8;
    localparam int ADDR_W = 3;

    logic              clk;
    logic              rst;
    logic              mode;
    logic              push;
    logic              pop;
    logic [DATA_W-1:0] din;
    logic [DATA_W-1:0] dout0;
    logic [DATA_W-1:0] dout1;
    logic [ADDR_W:0]   count;
    logic              empty;
    logic              full;
    logic              err;

    int errors = 0;
    int checks = 0;

    logic [DATA_W-1:0] m_items[$];
    bit                m_mode_q;
    bit                m_err;

    stack_queue_buffer #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst(rst), .mode(mode), .push(push), .pop(pop), .din(din),
        .dout0(dout0), .dout1(dout1), .count(count), .empty(empty), .full(full), .err(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, got timeout want completion");
        $fatal(1, "[TB] watchdog expired");
    end

    // Model: for a stack the top is the last element, for a queue the front is the first.
    task automatic model_apply(input bit p, input bit q, input logic [DATA_W-1:0] d, input bit m);
        logic [DATA_W-1:0] tmp;
        m_err = 1'b0;
        if (m != m_mode_q) begin
            m_items.delete();
            m_mode_q = m;
        end else if (p && q) begin
            if (m_items.size() == 0) begin
                m_items.push_back(d);
                m_err = 1'b1;
            end else if (m) begin
                m_items[m_items.size()-1] = d;
            end else begin
                tmp = m_items.pop_front();
                m_items.push_back(d);
            end
        end else if (p) begin
            if (m_items.size() == DEPTH) m_err = 1'b1;
            else m_items.push_back(d);
        end else if (q) begin
            if (m_items.size() == 0) m_err = 1'b1;
            else if (m) tmp = m_items.pop_back();
            else tmp = m_items.pop_front();
        end
    endtask

    function automatic logic [DATA_W-1:0] exp_dout0();
        if (m_items.size() < 1) return '0;
        return m_mode_q ? m_items[m_items.size()-1] : m_items[0];
    endfunction

    function automatic logic [DATA_W-1:0] exp_dout1();
        if (m_items.size() < 2) return '0;
        return m_mode_q ? m_items[m_items.size()-2] : m_items[1];
    endfunction

    // Called just after a falling edge; returns at the next falling edge.
    task automatic do_cycle(input bit p, input bit q, input logic [DATA_W-1:0] d, input bit m);
        push = p;
        pop  = q;
        din  = d;
        mode = m;
        @(posedge clk);
        model_apply(p, q, d, m);
        @(negedge clk);
        push = 1'b0;
        pop  = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0; mode = 1'b1; push = 1'b0; pop = 1'b0; din = '0;
        m_items.delete(); m_mode_q = 1'b1;
        #2;
        checks++; if (count !== 4'd0) begin errors++; $display("FAIL reset_count: got %0d want 0", count); end
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL reset_empty: got %b want 1", empty); end
        checks++; if (full !== 1'b0) begin errors++; $display("FAIL reset_full: got %b want 0", full); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b want 0", err); end
        checks++; if (dout0 !== '0) begin errors++; $display("FAIL reset_dout0: got %h want 0", dout0); end
        @(negedge clk);
        rst = 1'b1;
        do_cycle(0, 0, '0, 1);
    endtask

    task automatic test_stack_basic();
        do_cycle(1, 0, 32'h11, 1);
        do_cycle(1, 0, 32'h22, 1);
        do_cycle(1, 0, 32'h33, 1);
        checks++; if (dout0 !== 32'h33) begin errors++; $display("FAIL stack_dout0: got %h want 33", dout0); end
        checks++; if (dout1 !== 32'h22) begin errors++; $display("FAIL stack_dout1: got %h want 22", dout1); end
        checks++; if (count !== 4'd3) begin errors++; $display("FAIL stack_count: got %0d want 3", count); end
        do_cycle(0, 1, '0, 1);
        checks++; if (dout0 !== 32'h22) begin errors++; $display("FAIL stack_pop_dout0: got %h want 22", dout0); end
        checks++; if (dout1 !== 32'h11) begin errors++; $display("FAIL stack_pop_dout1: got %h want 11", dout1); end
        do_cycle(0, 1, '0, 1);
        do_cycle(0, 1, '0, 1);
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL stack_empty: got %b want 1", empty); end
        checks++; if (dout0 !== '0 || dout1 !== '0) begin errors++; $display("FAIL stack_empty_douts: got %h/%h want 0/0", dout0, dout1); end
    endtask

    task automatic test_queue_wrap();
        do_cycle(0, 0, '0, 0);
        checks++; if (count !== 4'd0) begin errors++; $display("FAIL queue_flip_count: got %0d want 0", count); end
        for (int k = 1; k <= 8; k++) do_cycle(1, 0, DATA_W'(k), 0);
        checks++; if (full !== 1'b1) begin errors++; $display("FAIL queue_full: got %b want 1", full); end
        do_cycle(1, 0, 32'h99, 0);
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL queue_overflow_err: got %b want 1", err); end
        checks++; if (count !== 4'd8) begin errors++; $display("FAIL queue_overflow_count: got %0d want 8", count); end
        do_cycle(0, 0, '0, 0);
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL queue_err_pulse: got %b want 0", err); end
        for (int k = 0; k < 3; k++) do_cycle(0, 1, '0, 0);
        for (int k = 9; k <= 11; k++) do_cycle(1, 0, DATA_W'(k), 0);
        for (int k = 4; k <= 11; k++) begin
            checks++; if (dout0 !== DATA_W'(k)) begin errors++; $display("FAIL queue_order: got %0d want %0d", dout0, k); end
            do_cycle(0, 1, '0, 0);
        end
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL queue_drained: got %b want 1", empty); end
    endtask

    task automatic test_simultaneous();
        do_cycle(0, 0, '0, 1);
        do_cycle(1, 0, 32'h5, 1);
        do_cycle(1, 0, 32'h7, 1);
        do_cycle(1, 1, 32'h9, 1);
        checks++; if (dout0 !== 32'h9) begin errors++; $display("FAIL sim_stack_dout0: got %h want 9", dout0); end
        checks++; if (dout1 !== 32'h5) begin errors++; $display("FAIL sim_stack_dout1: got %h want 5", dout1); end
        checks++; if (count !== 4'd2) begin errors++; $display("FAIL sim_stack_count: got %0d want 2", count); end
        do_cycle(0, 0, '0, 0);
        do_cycle(1, 0, 32'hA, 0);
        do_cycle(1, 1, 32'hB, 0);
        checks++; if (dout0 !== 32'hB) begin errors++; $display("FAIL sim_queue_dout0: got %h want b", dout0); end
        checks++; if (count !== 4'd1) begin errors++; $display("FAIL sim_queue_count: got %0d want 1", count); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL sim_queue_err: got %b want 0", err); end
        do_cycle(0, 1, '0, 0);
        do_cycle(1, 1, 32'hC, 0);
        checks++; if (count !== 4'd1) begin errors++; $display("FAIL sim_empty_count: got %0d want 1", count); end
        checks++; if (dout0 !== 32'hC) begin errors++; $display("FAIL sim_empty_dout0: got %h want c", dout0); end
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL sim_empty_err: got %b want 1", err); end
        do_cycle(0, 0, '0, 0);
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL sim_empty_err_pulse: got %b want 0", err); end
    endtask

    task automatic test_mode_flip();
        do_cycle(0, 0, '0, 1);
        for (int k = 1; k <= 3; k++) do_cycle(1, 0, DATA_W'(k), 1);
        checks++; if (count !== 4'd3) begin errors++; $display("FAIL flip_pre_count: got %0d want 3", count); end
        do_cycle(1, 0, 32'h77, 0);
        checks++; if (count !== 4'd0) begin errors++; $display("FAIL flip_count: got %0d want 0", count); end
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL flip_empty: got %b want 1", empty); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL flip_err: got %b want 0", err); end
        checks++; if (dout0 !== '0) begin errors++; $display("FAIL flip_dout0: got %h want 0", dout0); end
    endtask

    task automatic test_async_reset();
        for (int k = 1; k <= 5; k++) do_cycle(1, 0, DATA_W'(k + 32'h40), 0);
        checks++; if (count !== 4'd5) begin errors++; $display("FAIL areset_pre_count: got %0d want 5", count); end
        #2;
        rst = 1'b0;
        #1;
        checks++; if (count !== 4'd0) begin errors++; $display("FAIL areset_count: got %0d want 0", count); end
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL areset_empty: got %b want 1", empty); end
        checks++; if (dout0 !== '0) begin errors++; $display("FAIL areset_dout0: got %h want 0", dout0); end
        m_items.delete();
        m_mode_q = 1'b1;
        @(negedge clk);
        rst = 1'b1;
        do_cycle(0, 0, '0, 0);
        do_cycle(0, 1, '0, 0);
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL areset_pop_err: got %b want 1", err); end
    endtask

    task automatic test_random();
        bit p, q, m;
        m = mode;
        for (int i = 0; i < 600; i++) begin
            p = ($urandom_range(0, 99) < 55);
            q = ($urandom_range(0, 99) < 45);
            if ($urandom_range(0, 39) == 0) m = ~m;
            do_cycle(p, q, $urandom, m);
            checks++; if (count !== (ADDR_W+1)'(m_items.size())) begin errors++; $display("FAIL rand_count[%0d]: got %0d want %0d", i, count, m_items.size()); end
            checks++; if (dout0 !== exp_dout0()) begin errors++; $display("FAIL rand_dout0[%0d]: got %h want %h", i, dout0, exp_dout0()); end
            checks++; if (dout1 !== exp_dout1()) begin errors++; $display("FAIL rand_dout1[%0d]: got %h want %h", i, dout1, exp_dout1()); end
            checks++; if (err !== m_err) begin errors++; $display("FAIL rand_err[%0d]: got %b want %b", i, err, m_err); end
            checks++; if (empty !== (m_items.size() == 0) || full !== (m_items.size() == DEPTH)) begin
                errors++; $display("FAIL rand_flags[%0d]: got empty=%b full=%b want size %0d", i, empty, full, m_items.size());
            end
        end
    endtask

    initial begin
        test_reset();
        test_stack_basic();
        test_queue_wrap();
        test_simultaneous();
        test_mode_flip();
        test_async_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
